// File: rtl/mode_ctrl_pkg.sv
// Shared mode encodings for the mode_ctrl front end.
package mode_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_CARRY  = 2'd1,
        MODE_MAX    = 2'd2
    } mode_t;

endpackage

// File: rtl/mode_ctrl_if.sv
// Board-side buttons and mode-selector controls of mode_ctrl.
// master: drives the raw buttons; slave: the controller itself.
interface mode_ctrl_if;
    import mode_ctrl_pkg::*;

    logic  btn_mode;
    logic  btn_learn;
    logic  carry_set;
    logic  max_set;
    logic  refresh_limits;
    logic  hold_cnt;
    mode_t mode;

    modport master (
        output btn_mode,
        output btn_learn,
        input  carry_set,
        input  max_set,
        input  refresh_limits,
        input  hold_cnt,
        input  mode
    );

    modport slave (
        input  btn_mode,
        input  btn_learn,
        output carry_set,
        output max_set,
        output refresh_limits,
        output hold_cnt,
        output mode
    );
endinterface

// File: rtl/mode_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debounce counter, stable level
// and a one-cycle pulse on the clock after the stable level rises.
module mode_ctrl_btn_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic stable_o,
    output logic rise_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          stable_dly_q;
    logic          rise_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count clocks of disagreement; the clock that would reach DEB_CYCLES
    // flips the stable level and clears the counter so it can never wrap.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == DEB_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer, debounce state and rise-pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            rise_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            rise_q       <= stable_q & ~stable_dly_q;
            cnt_q        <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
endmodule

// File: rtl/mode_ctrl.sv
// Mode selector front end: debounced mode button steps SINGLE->CARRY->MAX,
// learn button holds the counter and, on a long press, strobes refresh_limits.
// Optional macro MODE_CTRL_LEARN_AUTO_MAX_EN: the refresh also forces MAX.
module mode_ctrl
    import mode_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = 1000,
    parameter int LONG_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    mode_ctrl_if.slave  bus
);
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_TC   = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic          mode_rise;
    logic          mode_stable;
    logic          learn_rise;
    logic          learn_stable;
    logic          mode_evt;
    logic [LW-1:0] lp_cnt_q, lp_cnt_d;
    logic          refresh_q, refresh_d;
    logic          hold_q;
    mode_t         state_q, state_d;
    logic          carry_q, max_q;

    mode_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (bus.btn_mode),
        .stable_o (mode_stable),
        .rise_o   (mode_rise)
    );

    mode_ctrl_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_learn (
        .clk      (clk),
        .reset    (reset),
        .btn_i    (bus.btn_learn),
        .stable_o (learn_stable),
        .rise_o   (learn_rise)
    );

    // Long-press counter: zero while learn is released, saturates at
    // LONG_CYCLES so each press yields a single refresh.
    always_comb begin
        lp_cnt_d  = '0;
        refresh_d = 1'b0;
        if (learn_stable) begin
            lp_cnt_d = lp_cnt_q;
            if (lp_cnt_q != LONG_TC) begin
                lp_cnt_d = lp_cnt_q + LW'(1);
            end
            refresh_d = (lp_cnt_q == LONG_LAST);
        end
    end

    // Long-press counter, refresh strobe and hold level registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lp_cnt_q  <= '0;
            refresh_q <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            lp_cnt_q  <= lp_cnt_d;
            refresh_q <= refresh_d;
            hold_q    <= learn_stable;
        end
    end

    // Learn has priority: a mode press is dropped while learn is active or
    // on the refresh cycle (learn may have just been released then).
    assign mode_evt = mode_rise & ~learn_stable & ~learn_rise & ~refresh_q;

    // Mode FSM next state; registered outputs follow state_d.
    always_comb begin
        state_d = state_q;
`ifdef MODE_CTRL_LEARN_AUTO_MAX_EN
        if (refresh_q) begin
            state_d = MODE_MAX;
        end else if (mode_evt) begin
`else
        if (mode_evt) begin
`endif
            case (state_q)
                MODE_SINGLE: state_d = MODE_CARRY;
                MODE_CARRY:  state_d = MODE_MAX;
                default:     state_d = MODE_SINGLE;
            endcase
        end
    end

    // Mode state and decoded selector outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MODE_SINGLE;
            carry_q <= 1'b0;
            max_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= (state_d == MODE_CARRY);
            max_q   <= (state_d == MODE_MAX);
        end
    end

    assign bus.carry_set      = carry_q;
    assign bus.max_set        = max_q;
    assign bus.refresh_limits = refresh_q;
    assign bus.hold_cnt       = hold_q;
    assign bus.mode           = state_q;

    // The stable mode level has no consumer beyond its rise pulse.
    logic unused_ok;
    assign unused_ok = mode_stable;
endmodule

// File: tb/tb_mode_ctrl.sv
// Directed bench for mode_ctrl with DEB_CYCLES=4, LONG_CYCLES=16.
module tb_mode_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [1:0] exp_mode = 2'd0;

    mode_ctrl_if bus ();

    mode_ctrl #(.DEB_CYCLES(4), .LONG_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        return (m == 2'd2) ? 2'd0 : m + 2'd1;
    endfunction

    task automatic press_mode();
        bus.btn_mode = 1'b1;
        tick(20);
        bus.btn_mode = 1'b0;
        tick(20);
        exp_mode = next_mode(exp_mode);
    endtask

    task automatic test_reset();
        tick(2);
        n_vec++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL reset_mode: got %0d expected 0", bus.mode); end
        n_vec++; if (bus.carry_set !== 1'b0) begin n_err++; $display("FAIL reset_carry: got %b expected 0", bus.carry_set); end
        n_vec++; if (bus.max_set !== 1'b0) begin n_err++; $display("FAIL reset_max: got %b expected 0", bus.max_set); end
        n_vec++; if (bus.refresh_limits !== 1'b0) begin n_err++; $display("FAIL reset_refresh: got %b expected 0", bus.refresh_limits); end
        n_vec++; if (bus.hold_cnt !== 1'b0) begin n_err++; $display("FAIL reset_hold: got %b expected 0", bus.hold_cnt); end
        reset = 1'b0;
        tick(3);
    endtask

    task automatic test_mode_press();
        logic [1:0] nm;
        for (int s = 0; s < 3; s++) begin
            nm = next_mode(exp_mode);
            bus.btn_mode = 1'b1;
            tick(7);
            n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL press_early: got %0d expected %0d", bus.mode, exp_mode); end
            tick(1);
            n_vec++; if (bus.mode !== nm) begin n_err++; $display("FAIL press_mode: got %0d expected %0d", bus.mode, nm); end
            n_vec++; if (bus.carry_set !== (nm == 2'd1)) begin n_err++; $display("FAIL press_carry: got %b expected %b", bus.carry_set, (nm == 2'd1)); end
            n_vec++; if (bus.max_set !== (nm == 2'd2)) begin n_err++; $display("FAIL press_max: got %b expected %b", bus.max_set, (nm == 2'd2)); end
            tick(12);
            bus.btn_mode = 1'b0;
            tick(20);
            exp_mode = nm;
            n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL press_single_advance: got %0d expected %0d", bus.mode, exp_mode); end
        end
    endtask

    task automatic test_glitch();
        int changes;
        changes = 0;
        bus.btn_mode = 1'b1;
        tick(3);
        bus.btn_mode = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.mode !== exp_mode) changes++;
        end
        n_vec++; if (changes !== 0) begin n_err++; $display("FAIL glitch_changes: got %0d cycles off-mode expected 0", changes); end
        n_vec++; if (bus.carry_set !== (exp_mode == 2'd1)) begin n_err++; $display("FAIL glitch_carry: got %b expected %b", bus.carry_set, (exp_mode == 2'd1)); end
    endtask

    task automatic test_learn_long();
        int pulses, at;
        logic [1:0] m_after;
        press_mode();
`ifdef MODE_CTRL_LEARN_AUTO_MAX_EN
        m_after = 2'd2;
`else
        m_after = exp_mode;
`endif
        pulses = 0;
        at = -1;
        bus.btn_learn = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (bus.refresh_limits === 1'b1) begin pulses++; at = i; end
            if (i == 6) begin
                n_vec++; if (bus.hold_cnt !== 1'b0) begin n_err++; $display("FAIL long_hold_early: got %b expected 0", bus.hold_cnt); end
            end
            if (i == 7) begin
                n_vec++; if (bus.hold_cnt !== 1'b1) begin n_err++; $display("FAIL long_hold_rise: got %b expected 1", bus.hold_cnt); end
            end
            if (i == 22) begin
                n_vec++; if (bus.hold_cnt !== 1'b1) begin n_err++; $display("FAIL long_hold_at_refresh: got %b expected 1", bus.hold_cnt); end
            end
            if (i == 23) begin
                n_vec++; if (bus.mode !== m_after) begin n_err++; $display("FAIL long_mode_after_refresh: got %0d expected %0d", bus.mode, m_after); end
                n_vec++; if (bus.max_set !== (m_after == 2'd2)) begin n_err++; $display("FAIL long_max_after_refresh: got %b expected %b", bus.max_set, (m_after == 2'd2)); end
            end
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL long_refresh_count: got %0d expected 1", pulses); end
        n_vec++; if (at !== 22) begin n_err++; $display("FAIL long_refresh_cycle: got %0d expected 22", at); end
        bus.btn_learn = 1'b0;
        tick(6);
        n_vec++; if (bus.hold_cnt !== 1'b1) begin n_err++; $display("FAIL long_hold_before_fall: got %b expected 1", bus.hold_cnt); end
        tick(1);
        n_vec++; if (bus.hold_cnt !== 1'b0) begin n_err++; $display("FAIL long_hold_fall: got %b expected 0", bus.hold_cnt); end
        tick(20);
        exp_mode = m_after;
        n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL long_mode_final: got %0d expected %0d", bus.mode, exp_mode); end
    endtask

    task automatic test_learn_short();
        int pulses, hold_cycles;
        pulses = 0;
        hold_cycles = 0;
        bus.btn_learn = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            if (i == 11) bus.btn_learn = 1'b0;
            tick(1);
            if (bus.refresh_limits === 1'b1) pulses++;
            if (bus.hold_cnt === 1'b1) hold_cycles++;
        end
        n_vec++; if (pulses !== 0) begin n_err++; $display("FAIL short_refresh: got %0d pulses expected 0", pulses); end
        n_vec++; if (hold_cycles !== 10) begin n_err++; $display("FAIL short_hold_cycles: got %0d expected 10", hold_cycles); end
        n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL short_mode: got %0d expected %0d", bus.mode, exp_mode); end
    endtask

    task automatic test_learn_blocks_mode();
        bus.btn_learn = 1'b1;
        tick(8);
        bus.btn_mode = 1'b1;
        tick(20);
        bus.btn_mode = 1'b0;
        tick(12);
`ifdef MODE_CTRL_LEARN_AUTO_MAX_EN
        exp_mode = 2'd2;
`endif
        n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL block_mode_in_learn: got %0d expected %0d", bus.mode, exp_mode); end
        bus.btn_learn = 1'b0;
        tick(20);
        n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL block_mode_after_learn: got %0d expected %0d", bus.mode, exp_mode); end
        press_mode();
        n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL block_mode_resume: got %0d expected %0d", bus.mode, exp_mode); end
        n_vec++; if (bus.carry_set !== (exp_mode == 2'd1)) begin n_err++; $display("FAIL block_carry_resume: got %b expected %b", bus.carry_set, (exp_mode == 2'd1)); end
        n_vec++; if (bus.max_set !== (exp_mode == 2'd2)) begin n_err++; $display("FAIL block_max_resume: got %b expected %b", bus.max_set, (exp_mode == 2'd2)); end
    endtask

    task automatic test_reset_mid_press();
        int pulses, at;
        if (exp_mode == 2'd0) press_mode();
        bus.btn_learn = 1'b1;
        tick(14);
        n_vec++; if (bus.hold_cnt !== 1'b1) begin n_err++; $display("FAIL midrst_hold_before: got %b expected 1", bus.hold_cnt); end
        reset = 1'b1;
        #1;
        n_vec++; if (bus.mode !== 2'd0) begin n_err++; $display("FAIL midrst_mode: got %0d expected 0", bus.mode); end
        n_vec++; if (bus.hold_cnt !== 1'b0) begin n_err++; $display("FAIL midrst_hold: got %b expected 0", bus.hold_cnt); end
        n_vec++; if ((bus.carry_set | bus.max_set | bus.refresh_limits) !== 1'b0) begin n_err++; $display("FAIL midrst_outputs: got carry=%b max=%b refresh=%b expected all 0", bus.carry_set, bus.max_set, bus.refresh_limits); end
        exp_mode = 2'd0;
        tick(2);
        reset = 1'b0;
        pulses = 0;
        at = -1;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (bus.refresh_limits === 1'b1) begin pulses++; at = i; end
            if (i == 6) begin
                n_vec++; if (bus.hold_cnt !== 1'b0) begin n_err++; $display("FAIL midrst_rehold_early: got %b expected 0", bus.hold_cnt); end
            end
            if (i == 7) begin
                n_vec++; if (bus.hold_cnt !== 1'b1) begin n_err++; $display("FAIL midrst_rehold: got %b expected 1", bus.hold_cnt); end
            end
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL midrst_refresh_count: got %0d expected 1", pulses); end
        n_vec++; if (at !== 22) begin n_err++; $display("FAIL midrst_refresh_cycle: got %0d expected 22", at); end
        bus.btn_learn = 1'b0;
        tick(20);
`ifdef MODE_CTRL_LEARN_AUTO_MAX_EN
        exp_mode = 2'd2;
`endif
        n_vec++; if (bus.mode !== exp_mode) begin n_err++; $display("FAIL midrst_mode_final: got %0d expected %0d", bus.mode, exp_mode); end
    endtask

    initial begin
        bus.btn_mode  = 1'b0;
        bus.btn_learn = 1'b0;
        test_reset();
        test_mode_press();
        test_glitch();
        test_learn_long();
        test_learn_short();
        test_learn_blocks_mode();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
